// File: rtl/bpsk_symbol_serializer.sv
// BPSK symbol serializer: frames buffered payload words behind an alternating
// preamble and emits one phase symbol per rising edge of the divided clock.
// div_clk is treated purely as a data level sampled on mCLK.
//
// state    | meaning
// IDLE     | no frame in flight, phase held at 0
// PREAMBLE | emitting alternating 1,0,1,0... preamble symbols
// DATA     | shifting the current word out MSB first
module bpsk_symbol_serializer #(
  parameter int DATA_W       = 8,
  parameter int PREAMBLE_LEN = 16
) (
  input  logic              mCLK,
  input  logic              rst,
  input  logic              div_clk,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_last,
  output logic              data_ready,
  output logic              phase,
  output logic              tx_active,
  output logic              sym_strobe,
  output logic              underrun
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [7:0]       PRE_LEN = 8'(PREAMBLE_LEN);
  localparam logic [BIT_W-1:0] BITS    = BIT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t            state;
  logic              div_d;
  logic              sym_tick;
  logic [DATA_W-1:0] buf_data;
  logic              buf_last;
  logic              buf_full;
  logic [DATA_W-1:0] shreg;
  logic              cur_last;
  logic [7:0]        pre_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              pre_done;
  logic              word_done;
  logic              accept;
  logic              load_buf;

  assign sym_tick  = div_clk & ~div_d;
  assign pre_done  = (pre_cnt == PRE_LEN);
  assign word_done = (bit_cnt == BITS);
  assign accept    = data_valid & data_ready;

  // Buffer is handed to the shift register when the preamble finishes, or when
  // a non-final word finishes and a follow-on word is already waiting.
  always_comb begin
    load_buf = 1'b0;
    if (sym_tick && buf_full) begin
      if (state == PREAMBLE && pre_done)
        load_buf = 1'b1;
      else if (state == DATA && word_done && !cur_last)
        load_buf = 1'b1;
    end
  end

  // Edge detector history for the divided clock.
  always_ff @(posedge mCLK) begin
    if (rst) div_d <= 1'b0;
    else     div_d <= div_clk;
  end

  // Holding buffer; data_ready is registered so it stays low through reset
  // and rises one cycle after the buffer empties.
  always_ff @(posedge mCLK) begin
    if (rst) begin
      buf_data   <= '0;
      buf_last   <= 1'b0;
      buf_full   <= 1'b0;
      data_ready <= 1'b0;
    end else if (accept) begin
      buf_data   <= data_in;
      buf_last   <= data_last;
      buf_full   <= 1'b1;
      data_ready <= 1'b0;
    end else if (load_buf) begin
      buf_full   <= 1'b0;
      data_ready <= 1'b1;
    end else begin
      data_ready <= ~buf_full;
    end
  end

  // Frame sequencer with registered symbol outputs; everything advances only on sym_tick.
  always_ff @(posedge mCLK) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 1'b0;
      tx_active  <= 1'b0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
      shreg      <= '0;
      cur_last   <= 1'b0;
      pre_cnt    <= '0;
      bit_cnt    <= '0;
    end else begin
      sym_strobe <= 1'b0;
      case (state)
        IDLE: begin
          phase     <= 1'b0;
          tx_active <= 1'b0;
          if (sym_tick && buf_full) begin
            state     <= PREAMBLE;
            pre_cnt   <= '0;
            tx_active <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (sym_tick) begin
            if (!pre_done) begin
              phase      <= ~pre_cnt[0];
              sym_strobe <= 1'b1;
              pre_cnt    <= pre_cnt + 8'd1;
            end else if (load_buf) begin
              state      <= DATA;
              phase      <= buf_data[DATA_W-1];
              shreg      <= {buf_data[DATA_W-2:0], 1'b0};
              cur_last   <= buf_last;
              bit_cnt    <= BIT_W'(1);
              sym_strobe <= 1'b1;
            end else begin
              // Buffer can only be empty here if something went badly wrong.
              state     <= IDLE;
              phase     <= 1'b0;
              tx_active <= 1'b0;
              underrun  <= 1'b1;
            end
          end
        end
        DATA: begin
          if (sym_tick) begin
            if (!word_done) begin
              phase      <= shreg[DATA_W-1];
              shreg      <= {shreg[DATA_W-2:0], 1'b0};
              bit_cnt    <= bit_cnt + BIT_W'(1);
              sym_strobe <= 1'b1;
            end else if (load_buf) begin
              phase      <= buf_data[DATA_W-1];
              shreg      <= {buf_data[DATA_W-2:0], 1'b0};
              cur_last   <= buf_last;
              bit_cnt    <= BIT_W'(1);
              sym_strobe <= 1'b1;
            end else begin
              // Frame ends here; a missing follow-on word is an underrun.
              if (!cur_last) underrun <= 1'b1;
              state     <= IDLE;
              phase     <= 1'b0;
              tx_active <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          phase     <= 1'b0;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_symbol_serializer.sv
// Directed bench for bpsk_symbol_serializer (DATA_W=8, PREAMBLE_LEN=4,
// div_clk period 100 mCLK).
module tb_bpsk_symbol_serializer;

  logic       mCLK = 1'b0;
  logic       rst = 1'b1;
  logic       div_clk = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_last = 1'b0;
  logic       data_ready;
  logic       phase;
  logic       tx_active;
  logic       sym_strobe;
  logic       underrun;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          div_en = 1'b1;
  int          div_cnt = 0;
  logic [63:0] sym_hist = '0;
  int          sym_n = 0;

  bpsk_symbol_serializer #(.DATA_W(8), .PREAMBLE_LEN(4)) dut (
    .mCLK(mCLK), .rst(rst), .div_clk(div_clk),
    .data_in(data_in), .data_valid(data_valid), .data_last(data_last),
    .data_ready(data_ready), .phase(phase), .tx_active(tx_active),
    .sym_strobe(sym_strobe), .underrun(underrun)
  );

  always #5 mCLK = ~mCLK;

  // Divided clock: toggles every 50 mCLK cycles while enabled.
  always @(negedge mCLK) begin
    if (div_en) begin
      if (div_cnt == 49) begin
        div_clk = ~div_clk;
        div_cnt = 0;
      end else begin
        div_cnt = div_cnt + 1;
      end
    end
  end

  // Record the phase value of every strobed symbol.
  always @(negedge mCLK) begin
    if (sym_strobe === 1'b1) begin
      sym_hist = {sym_hist[62:0], phase};
      sym_n = sym_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tx(input string tag, input logic lvl, input int budget);
    int k = 0;
    while (tx_active !== lvl && k < budget) begin
      @(negedge mCLK);
      k++;
    end
    chk(tag, 64'(tx_active), 64'(lvl));
  endtask

  task automatic send(input string tag, input logic [7:0] d, input logic l);
    int k = 0;
    @(negedge mCLK);
    while (data_ready !== 1'b1 && k < 3000) begin
      @(negedge mCLK);
      k++;
    end
    if (data_ready !== 1'b1) chk({tag, "_ready"}, 64'(data_ready), 64'd1);
    data_in = d;
    data_last = l;
    data_valid = 1'b1;
    @(negedge mCLK);
    data_valid = 1'b0;
  endtask

  function automatic logic [63:0] last_bits(input int n);
    return sym_hist & ((64'd1 << n) - 64'd1);
  endfunction

  task automatic frame_check(input string tag, input int n0, input int exp_n, input logic [63:0] exp_bits);
    wait_tx({tag, "_start"}, 1'b1, 400);
    wait_tx({tag, "_end"}, 1'b0, 4000);
    chk({tag, "_count"}, 64'(sym_n - n0), 64'(exp_n));
    chk({tag, "_bits"}, last_bits(exp_n), exp_bits);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge mCLK);
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    int k;

    // Reset state
    repeat (3) @(negedge mCLK);
    chk("rst_ready", 64'(data_ready), 64'd0);
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_tx", 64'(tx_active), 64'd0);
    chk("rst_strobe", 64'(sym_strobe), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    rst = 1'b0;
    @(negedge mCLK);
    chk("rst_ready_rise", 64'(data_ready), 64'd1);

    // Single word 0xA5 with last
    n0 = sym_n;
    send("a5", 8'hA5, 1'b1);
    frame_check("a5", n0, 12, 64'hAA5);
    chk("a5_underrun", 64'(underrun), 64'd0);

    // Back-to-back 0xFF then 0x00(last), no gap
    n0 = sym_n;
    send("ff", 8'hFF, 1'b0);
    send("00", 8'h00, 1'b1);
    frame_check("b2b", n0, 20, 64'hAFF00);
    chk("b2b_underrun", 64'(underrun), 64'd0);

    // Underrun: 0x3C without last and nothing following
    n0 = sym_n;
    send("3c", 8'h3C, 1'b0);
    frame_check("urun", n0, 12, 64'hA3C);
    chk("urun_flag", 64'(underrun), 64'd1);
    repeat (200) @(negedge mCLK);
    chk("urun_sticky", 64'(underrun), 64'd1);
    do_reset();
    @(negedge mCLK);
    chk("urun_cleared", 64'(underrun), 64'd0);

    // Reset during the 3rd data symbol
    n0 = sym_n;
    send("rst_mid", 8'hA5, 1'b1);
    k = 0;
    while (sym_n - n0 < 7 && k < 3000) begin
      @(negedge mCLK);
      k++;
    end
    chk("mid_reach", 64'(sym_n - n0), 64'd7);
    repeat (10) @(negedge mCLK);
    rst = 1'b1;
    @(negedge mCLK);
    chk("mid_phase", 64'(phase), 64'd0);
    chk("mid_tx", 64'(tx_active), 64'd0);
    chk("mid_strobe", 64'(sym_strobe), 64'd0);
    rst = 1'b0;
    n0 = sym_n;
    repeat (300) @(negedge mCLK);
    chk("mid_quiet", 64'(sym_n - n0), 64'd0);
    n0 = sym_n;
    send("5a", 8'h5A, 1'b1);
    frame_check("after_rst", n0, 12, 64'hA5A);

    // Stalled div_clk with a word held, plus a rejected offer
    div_en = 1'b0;
    n0 = sym_n;
    send("81", 8'h81, 1'b1);
    repeat (500) @(negedge mCLK);
    chk("stall_ready", 64'(data_ready), 64'd0);
    chk("stall_tx", 64'(tx_active), 64'd0);
    chk("stall_strobes", 64'(sym_n - n0), 64'd0);
    data_in = 8'h42;
    data_last = 1'b0;
    data_valid = 1'b1;
    repeat (10) @(negedge mCLK);
    data_in = 8'h99;
    repeat (10) @(negedge mCLK);
    data_valid = 1'b0;
    chk("offer_ready", 64'(data_ready), 64'd0);
    div_en = 1'b1;
    frame_check("stall", n0, 12, 64'hA81);
    chk("stall_underrun", 64'(underrun), 64'd0);
    repeat (300) @(negedge mCLK);
    chk("stall_no_extra", 64'(sym_n - n0), 64'd12);
    chk("stall_ready_end", 64'(data_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
